// File: rtl/dtree_pkg.sv
// Shared types and constants for the sequential decision-tree engine:
// tree geometry, node word layout, FSM states and node decode helpers.
package dtree_pkg;

    localparam int N_FEAT    = 18;
    localparam int FEAT_W    = 8;
    localparam int FIDX_W    = 5;
    localparam int N_NODES   = 128;
    localparam int NIDX_W    = 7;
    localparam int CLASS_W   = 2;
    localparam int MAX_DEPTH = 12;

    function automatic int calc_node_w(input int fidx_w, input int feat_w, input int nidx_w);
        return 1 + 3 + fidx_w + feat_w + 2 * nidx_w;
    endfunction

    localparam int NODE_W = calc_node_w(FIDX_W, FEAT_W, NIDX_W);

    // Node word, MSB to LSB: {internal, shift[2:0], fidx, thr, left, right}
    localparam int RIGHT_LSB = 0;
    localparam int LEFT_LSB  = RIGHT_LSB + NIDX_W;
    localparam int THR_LSB   = LEFT_LSB + NIDX_W;
    localparam int FIDX_LSB  = THR_LSB + FEAT_W;
    localparam int SHIFT_LSB = FIDX_LSB + FIDX_W;
    localparam int INT_BIT   = SHIFT_LSB + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              internal;
        logic [2:0]        shift;
        logic [FIDX_W-1:0] fidx;
        logic [FEAT_W-1:0] thr;
        logic [NIDX_W-1:0] left;
        logic [NIDX_W-1:0] right;
    } node_t;

    function automatic node_t unpack_node(input logic [NODE_W-1:0] w);
        node_t n;
        n.internal = w[INT_BIT];
        n.shift    = w[SHIFT_LSB +: 3];
        n.fidx     = w[FIDX_LSB +: FIDX_W];
        n.thr      = w[THR_LSB +: FEAT_W];
        n.left     = w[LEFT_LSB +: NIDX_W];
        n.right    = w[RIGHT_LSB +: NIDX_W];
        return n;
    endfunction

    function automatic logic is_leaf(input node_t n);
        return !n.internal;
    endfunction

    // A leaf keeps its class in the lowest bits of the word, i.e. inside 'right'.
    function automatic logic [CLASS_W-1:0] leaf_class(input node_t n);
        return n.right[CLASS_W-1:0];
    endfunction

endpackage

// File: rtl/dtree_seq_engine_if.sv
// Feature-in / result-out handshakes and node-table config port of the
// decision-tree engine, with engine (slave) and environment (master) views.
interface dtree_seq_engine_if;
    import dtree_pkg::*;

    // Both streams use strict valid/ready: a transfer happens on a rising edge
    // where valid && ready; valid and its payload stay stable until then.
    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic [NIDX_W-1:0]        out_depth;
    logic                     out_err;
    logic                     cfg_we;
    logic [NIDX_W-1:0]        cfg_addr;
    logic [NODE_W-1:0]        cfg_wdata;
    logic                     cfg_drop;

    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_class, out_depth, out_err, cfg_drop
    );

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_class, out_depth, out_err, cfg_drop
    );

endinterface

// File: rtl/dtree_node_ram.sv
// Node table: N_NODES x NODE_W register file, cleared to all-leaf-class-0
// by synchronous reset, one write port and one asynchronous read port.
module dtree_node_ram
    import dtree_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [NIDX_W-1:0] waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [NIDX_W-1:0] raddr,
    output logic [NODE_W-1:0] rdata
);

    logic [NODE_W-1:0] mem [N_NODES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtree_seq_engine.sv
// Programmable decision-tree classifier walking one node per clock.
// Optional DTREE_STATS_EN adds saturating completion and error counters.
module dtree_seq_engine
    import dtree_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef DTREE_STATS_EN
    output logic [31:0]        stat_infer,
    output logic [15:0]        stat_err,
`endif
    dtree_seq_engine_if.slave  bus,
    output state_t             dbg_state
);

    localparam logic [FIDX_W-1:0] FIDX_LIMIT  = FIDX_W'(N_FEAT);
    localparam logic [NIDX_W-1:0] DEPTH_LIMIT = NIDX_W'(MAX_DEPTH);

    state_t                   state_q, state_d;
    logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
    logic [NIDX_W-1:0]        cur_q, cur_d;
    logic [NIDX_W-1:0]        depth_q, depth_d;
    logic [CLASS_W-1:0]       class_q, class_d;
    logic                     err_q, err_d;
    logic                     valid_q, drop_q;
    logic                     in_ready, ram_we, fire, go;
    logic [NODE_W-1:0]        node_word;
    node_t                    node;
    logic [FEAT_W-1:0]        fval;

    dtree_node_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_wdata),
        .raddr (cur_q),
        .rdata (node_word)
    );

    assign node = unpack_node(node_word);

    // Explicit mux so an out-of-range fidx never indexes past the vector.
    always_comb begin
        fval = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (node.fidx == FIDX_W'(i)) fval = feat_q[i*FEAT_W +: FEAT_W];
        end
    end

    assign go   = (fval >> node.shift) <= node.thr;
    assign fire = valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        feat_d   = feat_q;
        cur_d    = cur_q;
        depth_d  = depth_q;
        class_d  = class_q;
        err_d    = err_q;
        in_ready = 1'b0;
        ram_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                ram_we   = bus.cfg_we;
                if (bus.in_valid) begin
                    feat_d  = bus.in_feat;
                    cur_d   = '0;
                    depth_d = '0;
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (is_leaf(node)) begin
                    class_d = leaf_class(node);
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (node.fidx >= FIDX_LIMIT || depth_q == DEPTH_LIMIT) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cur_d   = go ? node.left : node.right;
                    depth_d = depth_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // out_valid rises one cycle after entering DONE, giving the T+2+k latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q  <= '0;
            cur_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            feat_q  <= feat_d;
            cur_q   <= cur_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
            valid_q <= (state_q == ST_DONE) && !fire;
            drop_q  <= bus.cfg_we && (state_q != ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_class = class_q;
    assign bus.out_depth = depth_q;
    assign bus.out_err   = err_q;
    assign bus.cfg_drop  = drop_q;
    assign dbg_state     = state_q;

`ifdef DTREE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_infer <= '0;
            stat_err   <= '0;
        end else if (fire) begin
            if (stat_infer != '1)          stat_infer <= stat_infer + 1'b1;
            if (err_q && stat_err != '1)   stat_err   <= stat_err + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed plus randomized bench for dtree_seq_engine against a table-walking
// reference model; define DTREE_STATS_EN to also cover the counters.
module tb_dtree_seq_engine;
    import dtree_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
`ifdef DTREE_STATS_EN
    logic [31:0] stat_infer;
    logic [15:0] stat_err;
`endif

    dtree_seq_engine_if bus ();

    dtree_seq_engine dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DTREE_STATS_EN
        .stat_infer (stat_infer),
        .stat_err   (stat_err),
`endif
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int            checks   = 0;
    int            failures = 0;
    int            hs_cyc;
    logic [143:0]  cur_feat;
    logic [30:0]   tbl [128];

    function automatic logic [30:0] mk_node(input bit internal, input int shift, input int fidx,
                                            input int thr, input int left, input int right);
        return {internal, 3'(shift), 5'(fidx), 8'(thr), 7'(left), 7'(right)};
    endfunction

    function automatic logic [30:0] leaf(input int cls);
        return mk_node(1'b0, 0, 0, 0, 0, cls);
    endfunction

    function automatic logic [143:0] rand_feat();
        logic [143:0] f;
        for (int i = 0; i < 18; i++) f[i*8 +: 8] = 8'($urandom_range(0, 255));
        return f;
    endfunction

    // Reference walk straight from the tree rules over the shadow table.
    function automatic void model(input logic [143:0] f, output logic [1:0] c,
                                  output int d, output logic e);
        int cur, fidx, sh, thr;
        logic [30:0] w;
        logic [7:0]  fv;
        cur = 0; d = 0; c = 2'd0; e = 1'b0;
        for (int step = 0; step < 64; step++) begin
            w = tbl[cur];
            if (!w[30]) begin
                c = w[1:0];
                e = 1'b0;
                return;
            end
            fidx = int'(w[26:22]);
            sh   = int'(w[29:27]);
            thr  = int'(w[21:14]);
            if (fidx >= 18 || d == 12) begin
                c = 2'd0;
                e = 1'b1;
                return;
            end
            fv  = f[fidx*8 +: 8];
            cur = ((int'(fv) >> sh) <= thr) ? int'(w[13:7]) : int'(w[6:0]);
            d++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 128; i++) tbl[i] = '0;
    endtask

    task automatic cfg_write(input int addr, input logic [30:0] w, input bit applies);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 7'(addr);
        bus.cfg_wdata = w;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (applies) tbl[addr] = w;
    endtask

    task automatic start_vec(input string tag, input logic [143:0] f);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_feat  = f;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        hs_cyc   = cyc;
        cur_feat = f;
    endtask

    task automatic finish_vec(input string tag, input int stall);
        logic [1:0] ec;
        int         ed;
        logic       ee;
        int         n;
        logic [1:0] held_class;
        model(cur_feat, ec, ed, ee);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"},   32'(bus.out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - hs_cyc),  32'(2 + ed));
        chk({tag, "_class"},   32'(bus.out_class), 32'(ec));
        chk({tag, "_depth"},   32'(bus.out_depth), 32'(ed));
        chk({tag, "_err"},     32'(bus.out_err),   32'(ee));
        held_class = bus.out_class;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_stall_class"}, 32'(bus.out_class), 32'(held_class));
            chk({tag, "_stall_depth"}, 32'(bus.out_depth), 32'(ed));
            chk({tag, "_stall_ready"}, 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_after_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_after_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [143:0] f);
        start_vec(tag, f);
        finish_vec(tag, 0);
    endtask

    initial begin
        logic [143:0] f;

        bus.in_valid  = 1'b0;
        bus.in_feat   = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        for (int i = 0; i < 128; i++) tbl[i] = '0;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_class",     32'(bus.out_class), 32'd0);
        chk("rst_depth",     32'(bus.out_depth), 32'd0);
        chk("rst_err",       32'(bus.out_err),   32'd0);
        chk("rst_cfg_drop",  32'(bus.cfg_drop),  32'd0);
        rst = 1'b0;

        // Empty table: root is a class-0 leaf
        run_vec("empty", rand_feat());

        // Three-node tree on feature 7, top two bits vs threshold
        cfg_write(0, mk_node(1'b1, 6, 7, 3, 1, 2), 1'b1);
        cfg_write(1, leaf(1), 1'b1);
        cfg_write(2, leaf(3), 1'b1);
        f = rand_feat(); f[56 +: 8] = 8'hC0;
        run_vec("t3_c0", f);
        f = rand_feat(); f[56 +: 8] = 8'h00;
        run_vec("t3_00", f);
        cfg_write(0, mk_node(1'b1, 6, 7, 2, 1, 2), 1'b1);
        f = rand_feat(); f[56 +: 8] = 8'hC0;
        run_vec("t3_thr2", f);

        // Twelve-deep chain, then one more internal node to force the abort
        for (int i = 0; i < 12; i++) cfg_write(i, mk_node(1'b1, 0, 0, 255, i + 1, i + 1), 1'b1);
        cfg_write(12, leaf(2), 1'b1);
        run_vec("chain12", rand_feat());
        cfg_write(12, mk_node(1'b1, 0, 0, 255, 13, 13), 1'b1);
        run_vec("chain_abort", rand_feat());

        // Config write during a walk is dropped
        cfg_write(12, leaf(2), 1'b1);
        start_vec("drop", rand_feat());
        cfg_write(12, leaf(1), 1'b0);
        chk("drop_pulse", 32'(bus.cfg_drop), 32'd1);
        @(posedge clk); #1;
        chk("drop_pulse_end", 32'(bus.cfg_drop), 32'd0);
        finish_vec("drop", 0);

        // Reset in the middle of a walk
        start_vec("midrst", rand_feat());
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_class",     32'(bus.out_class), 32'd0);
        chk("midrst_depth",     32'(bus.out_depth), 32'd0);
        chk("midrst_err",       32'(bus.out_err),   32'd0);
        run_vec("cleared", rand_feat());

        // Out-of-range feature index, with the sink stalling
        cfg_write(0, mk_node(1'b1, 0, 20, 0, 1, 2), 1'b1);
        start_vec("fidx20", rand_feat());
        finish_vec("fidx20", 5);

        // Write landing on the same edge as the accepted vector is seen by the walk
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 7'd0;
        bus.cfg_wdata = leaf(2);
        start_vec("samecyc", rand_feat());
        bus.cfg_we = 1'b0;
        tbl[0] = leaf(2);
        finish_vec("samecyc", 0);

        // Random 16-node trees
        for (int t = 0; t < 4; t++) begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
                cfg_write(a, mk_node($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                                     $urandom_range(0, 19), $urandom_range(0, 255),
                                     $urandom_range(0, 15), $urandom_range(0, 15)), 1'b1);
            end
            for (int v = 0; v < 10; v++) begin
                f = rand_feat();
                if ($urandom_range(0, 1) == 1) f[56 +: 8] = 8'($urandom_range(0, 3) << 6);
                run_vec("rand", f);
            end
        end

`ifdef DTREE_STATS_EN
        do_reset();
        chk("stat_rst_infer", stat_infer, 32'd0);
        chk("stat_rst_err",   32'(stat_err), 32'd0);
        cfg_write(0, leaf(1), 1'b1);
        for (int i = 0; i < 3; i++) run_vec("stat_good", rand_feat());
        cfg_write(0, mk_node(1'b1, 0, 20, 0, 1, 2), 1'b1);
        run_vec("stat_bad", rand_feat());
        chk("stat_infer", stat_infer, 32'd4);
        chk("stat_err",   32'(stat_err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
